// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag-bundle bit positions for the pipelined ALU.
package alu_pkg;

  localparam int unsigned OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] OP_ADD   = 4'd0;
  localparam logic [OPCODE_W-1:0] OP_SUB   = 4'd1;
  localparam logic [OPCODE_W-1:0] OP_AND   = 4'd2;
  localparam logic [OPCODE_W-1:0] OP_OR    = 4'd3;
  localparam logic [OPCODE_W-1:0] OP_XNOR  = 4'd4;
  localparam logic [OPCODE_W-1:0] OP_SGT   = 4'd5;
  localparam logic [OPCODE_W-1:0] OP_MIN   = 4'd6;
  localparam logic [OPCODE_W-1:0] OP_ROR   = 4'd7;
  localparam logic [OPCODE_W-1:0] OP_SNE   = 4'd8;
  localparam logic [OPCODE_W-1:0] OP_PASSB = 4'd9;

  localparam int unsigned FLAG_CARRY = 0;
  localparam int unsigned FLAG_ZERO  = 1;
  localparam int unsigned FLAG_NEG   = 2;
  localparam int unsigned FLAG_OVF   = 3;
  localparam int unsigned FLAG_ILL   = 4;
  localparam int unsigned FLAG_W     = 5;

endpackage

// File: rtl/alu_comb_core.sv
// Combinational ALU datapath: computes result and the full flag bundle from one operand set.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHIFT_W = 5
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [WIDTH-1:0]    input1,
  input  logic [WIDTH-1:0]    input2,
  input  logic [SHIFT_W-1:0]  shiftValue,
  output logic [WIDTH-1:0]    result,
  output logic [FLAG_W-1:0]   flags
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rot;
  int unsigned      amt;
  logic             carry;
  logic             ovf;
  logic             ill;

  assign sum  = {1'b0, input1} + {1'b0, input2};
  // Top bit of the extended difference is the unsigned borrow.
  assign diff = {1'b0, input1} - {1'b0, input2};
  assign amt  = 32'(shiftValue) % WIDTH;
  assign rot  = WIDTH'({input1, input1} >> amt);

  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    ill    = 1'b0;
    case (opcode)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = (input1[WIDTH-1] == input2[WIDTH-1]) && (sum[WIDTH-1] != input1[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        carry  = diff[WIDTH];
        ovf    = (input1[WIDTH-1] != input2[WIDTH-1]) && (diff[WIDTH-1] != input1[WIDTH-1]);
      end
      OP_AND:   result = input1 & input2;
      OP_OR:    result = input1 | input2;
      OP_XNOR:  result = ~(input1 ^ input2);
      OP_SGT:   result = {{(WIDTH-1){1'b0}}, ($signed(input1) > $signed(input2))};
      OP_MIN:   result = (input1 < input2) ? input1 : input2;
      OP_ROR:   result = rot;
      OP_SNE:   result = {{(WIDTH-1){1'b0}}, (input1 != input2)};
      OP_PASSB: result = input2;
      default:  ill = 1'b1;
    endcase
  end

  always_comb begin
    flags             = '0;
    flags[FLAG_CARRY] = carry;
    flags[FLAG_ZERO]  = (result == '0);
    flags[FLAG_NEG]   = result[WIDTH-1];
    flags[FLAG_OVF]   = ovf;
    flags[FLAG_ILL]   = ill;
  end

endmodule

// File: rtl/alu_pipe_core.sv
// Two-stage valid/ready ALU pipeline: operand register, then registered result and flags.
module alu_pipe_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHIFT_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inValid,
  output logic                inReady,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [WIDTH-1:0]    input1,
  input  logic [WIDTH-1:0]    input2,
  input  logic [SHIFT_W-1:0]  shiftValue,
  output logic                outValid,
  input  logic                outReady,
  output logic [WIDTH-1:0]    result,
  output logic                carryFlag,
  output logic                zeroFlag,
  output logic                negFlag,
  output logic                overflowFlag,
  output logic                illegalOp
);

  logic                s1_valid_q;
  logic [OPCODE_W-1:0] s1_op_q;
  logic [WIDTH-1:0]    s1_a_q;
  logic [WIDTH-1:0]    s1_b_q;
  logic [SHIFT_W-1:0]  s1_shift_q;

  logic                out_valid_q;
  logic [WIDTH-1:0]    result_q;
  logic [FLAG_W-1:0]   flags_q;

  logic [WIDTH-1:0]    comb_result;
  logic [FLAG_W-1:0]   comb_flags;
  logic                s1_adv;
  logic                s2_adv;

  assign s2_adv  = !out_valid_q || outReady;
  assign s1_adv  = !s1_valid_q || s2_adv;
  assign inReady = s1_adv;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_shift_q <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= inValid;
      if (inValid) begin
        s1_op_q    <= opcode;
        s1_a_q     <= input1;
        s1_b_q     <= input2;
        s1_shift_q <= shiftValue;
      end
    end
  end

  alu_comb_core #(
    .WIDTH   (WIDTH),
    .SHIFT_W (SHIFT_W)
  ) u_comb (
    .opcode     (s1_op_q),
    .input1     (s1_a_q),
    .input2     (s1_b_q),
    .shiftValue (s1_shift_q),
    .result     (comb_result),
    .flags      (comb_flags)
  );

  // Output bundle only changes on advance, so it is held bit-stable under backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_q <= comb_result;
        flags_q  <= comb_flags;
      end
    end
  end

  assign outValid     = out_valid_q;
  assign result       = result_q;
  assign carryFlag    = flags_q[FLAG_CARRY];
  assign zeroFlag     = flags_q[FLAG_ZERO];
  assign negFlag      = flags_q[FLAG_NEG];
  assign overflowFlag = flags_q[FLAG_OVF];
  assign illegalOp    = flags_q[FLAG_ILL];

endmodule

// File: tb/tb_alu_pipe_core.sv
// Scoreboard bench for alu_pipe_core: 8-bit instance under directed traffic, 16-bit spot checks.
module tb_alu_pipe_core;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XNOR_ = 4'd4;
  localparam logic [3:0] SGT = 4'd5, MIN = 4'd6, ROR = 4'd7, SNE = 4'd8, PASSB = 4'd9;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       inValid, inReady, outValid, outReady;
  logic [3:0] opcode;
  logic [7:0] input1, input2, result;
  logic [4:0] shiftValue;
  logic       carryFlag, zeroFlag, negFlag, overflowFlag, illegalOp;

  logic        w_inValid, w_inReady, w_outValid, w_outReady;
  logic [3:0]  w_opcode;
  logic [15:0] w_input1, w_input2, w_result;
  logic [4:0]  w_shiftValue;
  logic        w_carry, w_zero, w_neg, w_ovf, w_ill;

  alu_pipe_core #(.WIDTH(8), .SHIFT_W(5)) dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady), .opcode(opcode),
    .input1(input1), .input2(input2), .shiftValue(shiftValue), .outValid(outValid),
    .outReady(outReady), .result(result), .carryFlag(carryFlag), .zeroFlag(zeroFlag),
    .negFlag(negFlag), .overflowFlag(overflowFlag), .illegalOp(illegalOp)
  );

  alu_pipe_core #(.WIDTH(16), .SHIFT_W(5)) dut16 (
    .clk(clk), .reset(reset), .inValid(w_inValid), .inReady(w_inReady), .opcode(w_opcode),
    .input1(w_input1), .input2(w_input2), .shiftValue(w_shiftValue), .outValid(w_outValid),
    .outReady(w_outReady), .result(w_result), .carryFlag(w_carry), .zeroFlag(w_zero),
    .negFlag(w_neg), .overflowFlag(w_ovf), .illegalOp(w_ill)
  );

  // Flag vector order: {illegal, overflow, neg, zero, carry}
  typedef struct packed {
    logic [7:0] res;
    logic [4:0] flg;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [4:0] flags8();
    return {illegalOp, overflowFlag, negFlag, zeroFlag, carryFlag};
  endfunction

  function automatic logic [4:0] flags16();
    return {w_ill, w_ovf, w_neg, w_zero, w_carry};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Output-side scoreboard: one pop per output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && outValid && outReady) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_output: observed result %h expected no output", result);
      end else begin
        e = sb.pop_front();
        check("sb_result", {8'h00, result}, {8'h00, e.res});
        check("sb_flags", {11'h0, flags8()}, {11'h0, e.flg});
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [4:0] sh, input logic [7:0] er, input logic [4:0] ef);
    int   n;
    logic took;
    n = 0;
    took = 1'b0;
    opcode = op;
    input1 = a;
    input2 = b;
    shiftValue = sh;
    inValid = 1'b1;
    sb.push_back(exp_t'({er, ef}));
    while (!took && n < 50) begin
      @(negedge clk);
      took = inReady;
      @(posedge clk);
      #1;
      n++;
    end
    inValid = 1'b0;
    if (!took) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: observed inReady low for %0d cycles expected acceptance", n);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", 16'(sb.size()), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    inValid = 1'b0; outReady = 1'b1; opcode = '0; input1 = '0; input2 = '0; shiftValue = '0;
    w_inValid = 1'b0; w_outReady = 1'b1; w_opcode = '0; w_input1 = '0; w_input2 = '0;
    w_shiftValue = '0;
    #12;
    check("rst_outvalid", {15'h0, outValid}, 16'd0);
    check("rst_result", {8'h00, result}, 16'h0000);
    check("rst_flags", {11'h0, flags8()}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("inready_after_reset", {15'h0, inReady}, 16'd1);
    check("idle_outvalid", {15'h0, outValid}, 16'd0);
    check("w16_idle_outvalid", {15'h0, w_outValid}, 16'd0);
    @(posedge clk);
    #1;

    // Two-cycle latency on the first op
    send(ADD, 8'hFF, 8'h01, 5'd0, 8'h00, 5'b00011);
    @(negedge clk);
    check("lat_not_yet", {15'h0, outValid}, 16'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("lat_two_cycles", {15'h0, outValid}, 16'd1);
    @(posedge clk);
    #1;

    send(SUB,   8'h80, 8'h01, 5'd0, 8'h7F, 5'b01000);
    send(SUB,   8'h01, 8'h02, 5'd0, 8'hFF, 5'b00101);
    send(ROR,   8'h81, 8'h00, 5'd9, 8'hC0, 5'b00100);
    send(ROR,   8'h5A, 8'h00, 5'd0, 8'h5A, 5'b00000);
    send(SGT,   8'h01, 8'hFF, 5'd0, 8'h01, 5'b00000);
    send(MIN,   8'h01, 8'hFF, 5'd0, 8'h01, 5'b00000);
    send(SNE,   8'h33, 8'h33, 5'd0, 8'h00, 5'b00010);
    send(4'd12, 8'h12, 8'h34, 5'd3, 8'h00, 5'b10010);
    send(AND_,  8'hF0, 8'h3C, 5'd0, 8'h30, 5'b00000);
    send(OR_,   8'h0F, 8'h80, 5'd0, 8'h8F, 5'b00100);
    send(XNOR_, 8'hAA, 8'h55, 5'd0, 8'h00, 5'b00010);
    send(PASSB, 8'h12, 8'hA5, 5'd0, 8'hA5, 5'b00100);
    drain();

    // Burst of five with a three-cycle output stall
    fork
      begin
        for (int i = 0; i < 5; i++) send(ADD, 8'(i), 8'h01, 5'd0, 8'(i + 1), 5'b00000);
      end
      begin
        logic [15:0] held;
        logic        saw_low;
        repeat (2) @(posedge clk);
        #1;
        outReady = 1'b0;
        @(negedge clk);
        held = {3'b000, result, flags8()};
        saw_low = !inReady;
        repeat (2) begin
          @(negedge clk);
          check("stall_hold", {3'b000, result, flags8()}, held);
          if (!inReady) saw_low = 1'b1;
        end
        check("stall_outvalid", {15'h0, outValid}, 16'd1);
        check("inready_fell", {15'h0, saw_low}, 16'd1);
        @(posedge clk);
        #1;
        outReady = 1'b1;
      end
    join
    drain();

    // Async reset with two ops in flight
    outReady = 1'b0;
    send(ADD, 8'h10, 8'h20, 5'd0, 8'h30, 5'b00000);
    send(ADD, 8'h01, 8'h01, 5'd0, 8'h02, 5'b00000);
    @(negedge clk);
    check("inflight_outvalid", {15'h0, outValid}, 16'd1);
    check("inflight_inready", {15'h0, inReady}, 16'd0);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_outvalid", {15'h0, outValid}, 16'd0);
    check("async_rst_result", {8'h00, result}, 16'h0000);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    #1;
    send(ADD, 8'h02, 8'h03, 5'd0, 8'h05, 5'b00000);
    @(negedge clk);
    check("post_rst_not_yet", {15'h0, outValid}, 16'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("post_rst_lat", {15'h0, outValid}, 16'd1);
    @(posedge clk);
    #1;
    drain();

    // 16-bit instance
    w_opcode = ADD;
    w_input1 = 16'h7FFF;
    w_input2 = 16'h0001;
    w_inValid = 1'b1;
    @(negedge clk);
    check("w16_inready", {15'h0, w_inReady}, 16'd1);
    @(posedge clk);
    #1;
    w_opcode = ROR;
    w_input1 = 16'h0001;
    w_input2 = 16'h0000;
    w_shiftValue = 5'd17;
    @(posedge clk);
    #1;
    w_inValid = 1'b0;
    @(negedge clk);
    check("w16_add_valid", {15'h0, w_outValid}, 16'd1);
    check("w16_add_result", w_result, 16'h8000);
    check("w16_add_flags", {11'h0, flags16()}, 16'h000C);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("w16_ror_valid", {15'h0, w_outValid}, 16'd1);
    check("w16_ror_result", w_result, 16'h8000);
    check("w16_ror_flags", {11'h0, flags16()}, 16'h0004);
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
